// File: rtl/sys_clk_mgr.sv
// sys_clk_mgr: PLL-lock qualification, core reset sequencing and per-channel
// clock-enable dividers with glitch-free divide reload, all on sys_clk.
module sys_clk_mgr #(
  parameter int unsigned NCH      = 2,
  parameter int unsigned DIV_W    = 8,
  parameter int unsigned LOCK_CNT = 16,
  parameter int unsigned RST_HOLD = 8
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  input  logic [NCH*DIV_W-1:0] div_val,
  input  logic                 div_load,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 clr_lost,
  output logic                 core_rst_n,
  output logic                 ready,
  output logic [NCH-1:0]       ce,
  output logic                 lock_lost,
  output logic [7:0]           lost_cnt
);

  // One timer serves both QUALIFY and HOLD; it only has to reach the larger count minus one.
  localparam int unsigned TmrMax = (LOCK_CNT > RST_HOLD) ? LOCK_CNT : RST_HOLD;
  localparam int unsigned TmrW   = (TmrMax > 1) ? $clog2(TmrMax) : 1;
  localparam logic [TmrW-1:0] LockLast = TmrW'(LOCK_CNT - 1);
  localparam logic [TmrW-1:0] HoldLast = TmrW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    StWait,
    StQualify,
    StHold,
    StRun
  } state_e;

  state_e          state_q, state_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic            lock_meta_q, lock_s_q;
  logic            core_rst_n_q, ready_q;
  logic            lock_lost_q, lock_lost_d;
  logic [7:0]      lost_cnt_q, lost_cnt_d;
  logic            run;
  logic            loss_evt;

  // Two-flop synchronizer for the asynchronous PLL lock; lock_s_q is the usable lock.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
    end
  end

  // Sequencer next state: qualify lock for LOCK_CNT cycles, hold reset RST_HOLD cycles, run.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    case (state_q)
      StWait: begin
        if (lock_s_q) begin
          state_d = StQualify;
          tmr_d   = '0;
        end
      end
      StQualify: begin
        if (!lock_s_q) begin
          state_d = StWait;
        end else if (tmr_q == LockLast) begin
          state_d = StHold;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StHold: begin
        if (!lock_s_q) begin
          state_d = StWait;
        end else if (tmr_q == HoldLast) begin
          state_d = StRun;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s_q) begin
          state_d = StWait;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // State, timer and the registered reset/ready outputs, which move on the same edge as the state.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StWait;
      tmr_q        <= '0;
      core_rst_n_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmr_q        <= tmr_d;
      core_rst_n_q <= (state_d == StRun);
      ready_q      <= (state_d == StRun);
    end
  end

  assign run        = (state_q == StRun);
  assign core_rst_n = core_rst_n_q;
  assign ready      = ready_q;

  // Staying in HOLD/RUN needs lock_s=1 every cycle, so lock_s=0 there is always a 1->0 edge.
  assign loss_evt = ((state_q == StHold) || (state_q == StRun)) && !lock_s_q;

  // Loss bookkeeping: a loss coinciding with clr_lost wins and restarts the count at one.
  always_comb begin
    lock_lost_d = lock_lost_q;
    lost_cnt_d  = lost_cnt_q;
    if (loss_evt) begin
      lock_lost_d = 1'b1;
      if (clr_lost) begin
        lost_cnt_d = 8'd1;
      end else if (lost_cnt_q != 8'hff) begin
        lost_cnt_d = lost_cnt_q + 8'd1;
      end
    end else if (clr_lost) begin
      lock_lost_d = 1'b0;
      lost_cnt_d  = 8'd0;
    end
  end

  // Loss flag and saturating counter registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_lost_q <= 1'b0;
      lost_cnt_q  <= 8'd0;
    end else begin
      lock_lost_q <= lock_lost_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign lock_lost = lock_lost_q;
  assign lost_cnt  = lost_cnt_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             pend_q, pend_d;
    logic             active;
    logic             wrap;

    assign active = run && ch_en[i];
    assign wrap   = active && (cnt_q == act_q);
    // Combinational so a falling ch_en or leaving RUN silences the strobe in that same cycle.
    assign ce[i]  = wrap;

    // Divider next state; a pending divide is only adopted at a period boundary or while idle.
    always_comb begin
      cnt_d    = (active && !wrap) ? cnt_q + 1'b1 : '0;
      act_d    = act_q;
      shadow_d = shadow_q;
      pend_d   = pend_q;
      if (pend_q && (wrap || !active)) begin
        act_d  = shadow_q;
        pend_d = 1'b0;
      end
      // A load on a wrap cycle lands in pend_q after this wrap, so it waits for the next one.
      if (div_load) begin
        shadow_d = div_val[i*DIV_W +: DIV_W];
        pend_d   = 1'b1;
      end
    end

    // Divider counter, active divide, shadow and pending registers.
    always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        act_q    <= '0;
        shadow_q <= '0;
        pend_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        act_q    <= act_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
      end
    end
  end

endmodule

// File: doc/sys_clk_mgr.md
SYS_CLK_MGR -- requirements
Module: sys_clk_mgr

Interface
REQ-001 Parameter: NCH, default 2, number of clock-enable channels.
REQ-002 Parameter: DIV_W, default 8, width of each channel divide value.
REQ-003 Parameter: LOCK_CNT, default 16, consecutive synchronised-lock cycles required to qualify lock.
REQ-004 Parameter: RST_HOLD, default 8, cycles core reset is held after qualification.
REQ-005 Port: sys_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-007 Port: pll_lock  in  1  PLL lock, asynchronous to sys_clk.
REQ-008 Port: div_val  in  NCH*DIV_W  per-channel divide values; channel i in bits [i*DIV_W +: DIV_W].
REQ-009 Port: div_load  in  1  one-cycle strobe capturing div_val into the shadow registers.
REQ-010 Port: ch_en  in  NCH  per-channel enable.
REQ-011 Port: clr_lost  in  1  one-cycle strobe clearing lock_lost and lost_cnt.
REQ-012 Port: core_rst_n  out  1  registered active-low reset for downstream logic.
REQ-013 Port: ready  out  1  registered; high only in RUN.
REQ-014 Port: ce  out  NCH  per-channel clock-enable strobes.
REQ-015 Port: lock_lost  out  1  sticky lock-loss flag.
REQ-016 Port: lost_cnt  out  8  saturating count of lock-loss events.

Function
REQ-017 pll_lock SHALL pass through a 2-flop synchronizer; lock_s denotes the synchronizer output.
REQ-018 FSM states SHALL be WAIT, QUALIFY, HOLD and RUN.
REQ-019 WAIT SHALL move to QUALIFY on the first cycle with lock_s=1, clearing the qualify counter.
REQ-020 QUALIFY SHALL move to HOLD after LOCK_CNT consecutive lock_s=1 cycles, and SHALL return to WAIT on any lock_s=0.
REQ-021 HOLD SHALL move to RUN after exactly RST_HOLD cycles, and SHALL return to WAIT on lock_s=0.
REQ-022 RUN SHALL return to WAIT on lock_s=0.
REQ-023 core_rst_n and ready SHALL be 1 only in RUN, registered, changing on the same edge as the state.
REQ-024 Latency: first core_rst_n=1 cycle SHALL be 3+LOCK_CNT+RST_HOLD cycles after the first edge sampling pll_lock=1, with pll_lock held high.
REQ-025 A lock_s 1->0 transition in HOLD or RUN SHALL set lock_lost and increment lost_cnt, saturating at 255; drops in QUALIFY SHALL NOT count.
REQ-026 clr_lost SHALL clear lock_lost and lost_cnt; if it coincides with a loss event, the event wins (lock_lost=1, lost_cnt=1).
REQ-027 Each channel SHALL have a DIV_W-bit counter and an active divide register div_act[i].
REQ-028 Counter behaviour: held at 0 when not RUN or ch_en[i]=0; otherwise it increments and wraps to 0 when equal to div_act[i].
REQ-029 ce[i] SHALL be 1 exactly in cycles where RUN, ch_en[i]=1 and counter==div_act[i], giving one pulse per div_act[i]+1 cycles.
REQ-030 div_act=0 SHALL make ce[i] continuously high in RUN while enabled.
REQ-031 div_load SHALL capture div_val into the shadow registers and set a per-channel pending bit.
REQ-032 A pending shadow SHALL transfer to div_act[i] on that channel's next wrap, or on the next cycle if the channel is idle (disabled or not RUN), so ce periods never mix two values.
REQ-033 A div_load arriving on a wrap cycle SHALL take effect at the following wrap.
REQ-034 ch_en[i] falling SHALL zero ce[i] in the same cycle and clear the counter on the next edge.
REQ-035 Leaving RUN SHALL force all ce low combinationally from the state and clear all counters.

Reset
REQ-036 While rst_n=0, all of the following SHALL hold: state=WAIT, synchronizer=0, core_rst_n=0, ready=0, ce=0, lock_lost=0, lost_cnt=0, counters=0, div_act=0, shadows=0, pending=0.
REQ-037 Reset assertion SHALL act immediately (asynchronously); deassertion SHALL take effect on the next sys_clk edge, and FSM behaviour SHALL restart from WAIT.

Verification
REQ-038 Bring-up: LOCK_CNT=16, RST_HOLD=8, pll_lock high from cycle 0 -> core_rst_n and ready rise at cycle 27; ce=0 before that.
REQ-039 Glitch: pll_lock low for 3 cycles mid-QUALIFY -> return to WAIT, qualification restarts, lost_cnt stays 0.
REQ-040 Loss in RUN: pll_lock drops -> core_rst_n=0 and ready=0 3 cycles later, lock_lost=1, lost_cnt=1; relock repeats the 27-cycle sequence; 300 losses give lost_cnt=255.
REQ-041 Divider: ch0 div=3 and ch1 div=0, both enabled in RUN -> ce[0] high every 4th cycle, first on the 4th RUN cycle; ce[1] constantly high.
REQ-042 Reload: ch0 div=3 running, div_load with 1 mid-period -> the current 4-cycle period completes, then the period becomes 2; div_load on a wrap cycle is applied one wrap later.
REQ-043 Async reset mid-RUN with lock_lost=1 -> all outputs 0 immediately; after release with lock high, full bring-up in 27 cycles.
